// File: rtl/uart_transmitter_if.sv
// Character handshake between a producer and the UART transmit stage.
interface uart_transmitter_if;
  logic [6:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit stage: start, parity, d6..d0 MSB first, STOP_BITS stop bits, paced by tx_en.
// Define UART_TX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_transmitter #(
  parameter int unsigned STOP_BITS  = 1,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              tx_clk,
  input  logic              reset,
  input  logic              tx_en,
  uart_transmitter_if.slave bus,
  output logic              tx,
  output logic              busy,
  output logic              parity
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  if (STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_transmitter: illegal STOP_BITS or FIFO_DEPTH");
  end

  logic [1:0] state;
  logic [7:0] shreg;
  logic [3:0] bit_cnt;
  logic       buf_empty;
  logic [6:0] buf_data;
  logic       push;
  logic       pop;
  logic       frame_end;
  logic       new_par;

  assign push      = bus.data_valid && bus.data_ready;
  assign frame_end = (state == STOP) && (bit_cnt == 4'(STOP_BITS - 1));
  // The strobe that closes the last stop period may launch the next frame directly.
  assign pop       = tx_en && !buf_empty && ((state == IDLE) || frame_end);
  assign new_par   = PARITY_ODD ? ~^buf_data : ^buf_data;
  assign busy      = (state != IDLE);

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [6:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  always_ff @(posedge tx_clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign buf_empty      = (count == '0);
  assign buf_data       = mem[rd_ptr];
  assign bus.data_ready = (count != (PW + 1)'(FIFO_DEPTH));
`else
  logic [6:0] hold_reg;
  logic       hold_full;

  always_ff @(posedge tx_clk) begin
    if (push) hold_reg <= bus.data_in;
  end

  always_ff @(posedge tx_clk) begin
    if (reset)     hold_full <= 1'b0;
    else if (push) hold_full <= 1'b1;
    else if (pop)  hold_full <= 1'b0;
  end

  assign buf_empty      = !hold_full;
  assign buf_data       = hold_reg;
  assign bus.data_ready = !hold_full;
`endif

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      parity  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (tx_en) begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= SEND;
            tx      <= 1'b0;
            shreg   <= {new_par, buf_data};
            parity  <= new_par;
            bit_cnt <= '0;
          end
        end
        SEND: begin
          if (bit_cnt == 4'd8) begin
            tx      <= 1'b1;
            state   <= STOP;
            bit_cnt <= '0;
          end else begin
            tx      <= shreg[7];
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (frame_end) begin
            bit_cnt <= '0;
            if (pop) begin
              state  <= SEND;
              tx     <= 1'b0;
              shreg  <= {new_par, buf_data};
              parity <= new_par;
            end else begin
              state  <= IDLE;
              parity <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          parity  <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: dut0 (1 stop, even), dut1 (2 stop, odd parity).
module tb_uart_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic tx_en = 1'b0;
  logic tx0, busy0, par0, tx1, busy1, par1;

  uart_transmitter_if bus0 ();
  uart_transmitter_if bus1 ();

  uart_transmitter #(.STOP_BITS(1), .PARITY_ODD(1'b0), .FIFO_DEPTH(4)) dut0 (
    .tx_clk(clk), .reset(reset), .tx_en(tx_en), .bus(bus0.slave),
    .tx(tx0), .busy(busy0), .parity(par0));

  uart_transmitter #(.STOP_BITS(2), .PARITY_ODD(1'b1), .FIFO_DEPTH(4)) dut1 (
    .tx_clk(clk), .reset(reset), .tx_en(tx_en), .bus(bus1.slave),
    .tx(tx1), .busy(busy1), .parity(par1));

  // Expected line sequences, first bit at the MSB.
  localparam logic [9:0]  F41_E = 10'b0010000011;
  localparam logic [9:0]  F07_E = 10'b0100001111;
  localparam logic [9:0]  F2A_E = 10'b0101010101;
  localparam logic [9:0]  F55_E = 10'b0010101011;
  localparam logic [10:0] F41_O = 11'b01100000111;
  localparam logic [10:0] F07_O = 11'b00000011111;

  int checks = 0;
  int passed = 0;

  bit strobe_on     = 1'b0;
  int strobe_period = 4;
  int div           = 0;

  always @(negedge clk) begin
    if (!strobe_on) begin
      tx_en = 1'b0;
      div   = 0;
    end else begin
      div++;
      if (div >= strobe_period) begin
        tx_en = 1'b1;
        div   = 0;
      end else begin
        tx_en = 1'b0;
      end
    end
  end

  task automatic push(input bit sel, input logic [6:0] d);
    @(negedge clk);
    if (sel) begin bus1.data_in = d; bus1.data_valid = 1'b1; end
    else     begin bus0.data_in = d; bus0.data_valid = 1'b1; end
    @(negedge clk);
    bus0.data_valid = 1'b0;
    bus1.data_valid = 1'b0;
  endtask

  task automatic stop_strobe();
    strobe_on = 1'b0;
    @(negedge clk);
  endtask

  // Records tx after each strobe edge, starting at the first low (start) bit.
  task automatic capture(input bit sel, input int nbits, output logic [31:0] bits, output bit ok);
    bit started = 1'b0;
    int got = 0;
    logic t;
    bits = '0;
    for (int c = 0; c < 2000 && got < nbits; c++) begin
      @(posedge clk);
      if (tx_en) begin
        #1;
        t = sel ? tx1 : tx0;
        if (!started && t == 1'b0) started = 1'b1;
        if (started) begin
          bits = {bits[30:0], t};
          got++;
        end
      end
    end
    ok = (got == nbits);
  endtask

  task automatic wait_strobes(input int n, output bit ok);
    int got = 0;
    for (int c = 0; c < 4000 && got < n; c++) begin
      @(posedge clk);
      if (tx_en) got++;
    end
    #1;
    ok = (got == n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx0 !== 1'b1) $display("FAIL reset_tx0: got %b expected 1", tx0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy0: got %b expected 0", busy0); else passed++;
    checks++; if (par0 !== 1'b0) $display("FAIL reset_par0: got %b expected 0", par0); else passed++;
    checks++; if (bus0.data_ready !== 1'b1) $display("FAIL reset_ready0: got %b expected 1", bus0.data_ready); else passed++;
    checks++; if (tx1 !== 1'b1) $display("FAIL reset_tx1: got %b expected 1", tx1); else passed++;
    checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b expected 0", busy1); else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] cap;
    bit ok, ok2;
    push(1'b0, 7'h41);
    strobe_on = 1'b1;
    capture(1'b0, 10, cap, ok);
    checks++; if (!ok || cap[9:0] !== F41_E) $display("FAIL basic_frame41: got %b (done=%0d) expected %b", cap[9:0], ok, F41_E); else passed++;
    wait_strobes(1, ok2);
    checks++; if (!ok2 || busy0 !== 1'b0 || tx0 !== 1'b1) $display("FAIL basic_idle: busy=%b tx=%b expected busy=0 tx=1", busy0, tx0); else passed++;
    stop_strobe();
  endtask

  task automatic test_parity();
    logic [31:0] cap;
    bit ok, ok2;
    push(1'b0, 7'h07);
    strobe_on = 1'b1;
    capture(1'b0, 10, cap, ok);
    checks++; if (!ok || cap[9:0] !== F07_E) $display("FAIL even_frame07: got %b expected %b", cap[9:0], F07_E); else passed++;
    checks++; if (busy0 !== 1'b1 || par0 !== 1'b1) $display("FAIL even_parity_out: busy=%b parity=%b expected 1 1", busy0, par0); else passed++;
    wait_strobes(1, ok2);
    checks++; if (!ok2 || busy0 !== 1'b0 || par0 !== 1'b0) $display("FAIL even_end: busy=%b parity=%b expected 0 0", busy0, par0); else passed++;
    stop_strobe();
    push(1'b1, 7'h07);
    strobe_on = 1'b1;
    capture(1'b1, 11, cap, ok);
    checks++; if (!ok || cap[10:0] !== F07_O) $display("FAIL odd_frame07: got %b expected %b", cap[10:0], F07_O); else passed++;
    checks++; if (busy1 !== 1'b1 || tx1 !== 1'b1) $display("FAIL odd_second_stop: busy=%b tx=%b expected 1 1", busy1, tx1); else passed++;
    wait_strobes(1, ok2);
    checks++; if (!ok2 || busy1 !== 1'b0) $display("FAIL odd_end: busy=%b expected 0", busy1); else passed++;
    stop_strobe();
  endtask

  task automatic test_fast_strobe();
    logic [31:0] cap;
    bit ok, ok2;
    strobe_period = 1;
    push(1'b0, 7'h2A);
    strobe_on = 1'b1;
    capture(1'b0, 10, cap, ok);
    checks++; if (!ok || cap[9:0] !== F2A_E) $display("FAIL fast_frame2a: got %b expected %b", cap[9:0], F2A_E); else passed++;
    wait_strobes(1, ok2);
    checks++; if (!ok2 || busy0 !== 1'b0) $display("FAIL fast_end: busy=%b expected 0", busy0); else passed++;
    stop_strobe();
    strobe_period = 4;
  endtask

  task automatic test_back_to_back();
    logic [31:0] cap;
    bit ok, ok2;
    bit seen = 1'b0;
    push(1'b1, 7'h41);
    strobe_on = 1'b1;
    fork
      capture(1'b1, 22, cap, ok);
      begin
        for (int c = 0; c < 200 && !seen; c++) begin
          @(negedge clk);
          if (busy1) seen = 1'b1;
        end
        push(1'b1, 7'h07);
      end
    join
    checks++; if (!ok || cap[21:0] !== {F41_O, F07_O}) $display("FAIL b2b_frames: got %b expected %b", cap[21:0], {F41_O, F07_O}); else passed++;
    wait_strobes(1, ok2);
    checks++; if (!ok2 || busy1 !== 1'b0 || tx1 !== 1'b1) $display("FAIL b2b_end: busy=%b tx=%b expected 0 1", busy1, tx1); else passed++;
    stop_strobe();
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo_full();
    logic [31:0] cap;
    logic [9:0]  exp_f [4];
    bit ok, ok2;
    exp_f[0] = F41_E; exp_f[1] = F07_E; exp_f[2] = F2A_E; exp_f[3] = F55_E;
    push(1'b0, 7'h41);
    push(1'b0, 7'h07);
    push(1'b0, 7'h2A);
    checks++; if (bus0.data_ready !== 1'b1) $display("FAIL fifo_ready_3: got %b expected 1", bus0.data_ready); else passed++;
    push(1'b0, 7'h55);
    checks++; if (bus0.data_ready !== 1'b0) $display("FAIL fifo_ready_4: got %b expected 0", bus0.data_ready); else passed++;
    push(1'b0, 7'h7F);
    checks++; if (bus0.data_ready !== 1'b0) $display("FAIL fifo_ready_5: got %b expected 0", bus0.data_ready); else passed++;
    strobe_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      capture(1'b0, 10, cap, ok);
      checks++; if (!ok || cap[9:0] !== exp_f[i]) $display("FAIL fifo_frame%0d: got %b expected %b", i, cap[9:0], exp_f[i]); else passed++;
    end
    wait_strobes(12, ok2);
    checks++; if (!ok2 || busy0 !== 1'b0 || tx0 !== 1'b1 || bus0.data_ready !== 1'b1)
      $display("FAIL fifo_drain: busy=%b tx=%b ready=%b expected 0 1 1", busy0, tx0, bus0.data_ready); else passed++;
    stop_strobe();
  endtask
`else
  task automatic test_ready_hold();
    logic [31:0] cap;
    bit ok, ok2;
    bit seen = 1'b0;
    push(1'b0, 7'h41);
    checks++; if (bus0.data_ready !== 1'b0) $display("FAIL hold_ready_full: got %b expected 0", bus0.data_ready); else passed++;
    push(1'b0, 7'h55);
    checks++; if (bus0.data_ready !== 1'b0) $display("FAIL hold_ready_drop: got %b expected 0", bus0.data_ready); else passed++;
    strobe_on = 1'b1;
    fork
      capture(1'b0, 10, cap, ok);
      begin
        for (int c = 0; c < 100 && !seen; c++) begin
          @(posedge clk);
          if (tx_en) begin
            seen = 1'b1;
            #1;
            checks++; if (bus0.data_ready !== 1'b1 || tx0 !== 1'b0) $display("FAIL hold_pop_edge: ready=%b tx=%b expected 1 0", bus0.data_ready, tx0); else passed++;
          end
        end
        push(1'b0, 7'h07);
        checks++; if (bus0.data_ready !== 1'b0) $display("FAIL hold_inflight_full: got %b expected 0", bus0.data_ready); else passed++;
      end
    join
    checks++; if (!ok || cap[9:0] !== F41_E) $display("FAIL hold_frame41: got %b expected %b", cap[9:0], F41_E); else passed++;
    checks++; if (bus0.data_ready !== 1'b0) $display("FAIL hold_stop_full: got %b expected 0", bus0.data_ready); else passed++;
    wait_strobes(1, ok2);
    checks++; if (!ok2 || bus0.data_ready !== 1'b1 || tx0 !== 1'b0 || par0 !== 1'b1)
      $display("FAIL hold_b2b_pop: ready=%b tx=%b parity=%b expected 1 0 1", bus0.data_ready, tx0, par0); else passed++;
    wait_strobes(10, ok2);
    checks++; if (!ok2 || busy0 !== 1'b0 || tx0 !== 1'b1) $display("FAIL hold_end: busy=%b tx=%b expected 0 1", busy0, tx0); else passed++;
    stop_strobe();
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    bit any_low = 1'b0;
    push(1'b0, 7'h41);
    strobe_on = 1'b1;
    wait_strobes(6, ok);
    checks++; if (!ok || tx0 !== 1'b0 || busy0 !== 1'b1) $display("FAIL mid_d3: tx=%b busy=%b expected 0 1", tx0, busy0); else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (tx0 !== 1'b1 || busy0 !== 1'b0 || bus0.data_ready !== 1'b1 || par0 !== 1'b0)
      $display("FAIL mid_reset: tx=%b busy=%b ready=%b parity=%b expected 1 0 1 0", tx0, busy0, bus0.data_ready, par0); else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (tx0 !== 1'b1 || busy0 !== 1'b0) any_low = 1'b1;
    end
    checks++; if (any_low !== 1'b0) $display("FAIL mid_no_more_bits: line activity after reset, got %b expected 0", any_low); else passed++;
    stop_strobe();
  endtask

  initial begin
    bus0.data_in = '0; bus0.data_valid = 1'b0;
    bus1.data_in = '0; bus1.data_valid = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_fast_strobe();
    test_back_to_back();
`ifdef UART_TX_FIFO_EN
    test_fifo_full();
`else
    test_ready_hold();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial transmit stage feeding the UART receiver: accepts 7-bit characters over a valid/ready handshake and serialises each one onto a single line.
- Frame, in line order: start (0), parity, d6..d0 (MSB first), stop (1) held for STOP_BITS bit periods.
- The parity bit is the XOR of the 7 data bits, which is even parity by default.
- Bit timing is set by an external bit-rate strobe `tx_en`, generated the same way as the receiver's `rx_en`.

Parameters:
- STOP_BITS, 1: number of stop-bit periods per frame; legal 1..2.
- PARITY_ODD, 0: 0 gives parity = ^data; 1 gives parity = ~^data.
- FIFO_DEPTH, 4: holding FIFO entries, power of 2, >= 2. Used only when UART_TX_FIFO_EN is defined.

Ports:
- tx_clk      input   1  sole clock; all state updates on the rising edge.
- reset       input   1  synchronous, active-high reset.
- tx_en       input   1  bit-rate strobe, one tx_clk cycle wide per bit period.
- data_in     input   7  character to send.
- data_valid  input   1  data_in is valid this cycle.
- data_ready  output  1  block can accept data_in this cycle.
- tx          output  1  serial line, registered, idles high.
- busy        output  1  frame in progress (state != IDLE).
- parity      output  1  parity bit of the frame currently being sent; 0 when idle.

Behaviour:
- Reset, sampled on a tx_clk edge with reset=1: tx=1, busy=0, parity=0, data_ready=1, buffer emptied, state=IDLE, bit counter=0.
- Reset mid-frame aborts the frame immediately: tx=1 on the same edge. Buffered data is discarded.
- Accept: on a rising edge with data_valid && data_ready, data_in is written into the buffer. data_ready does not depend combinationally on data_valid.
- Without FIFO: the buffer is a 1-entry holding register and data_ready = !hold_full.
- IDLE state:
  - tx=1.
  - On an edge with tx_en=1 and the buffer non-empty: pop the entry, compute parity, load shift register {parity, d6..d0}, drive tx<=0, go to SEND, set bit counter=0.
  - tx_en=1 with an empty buffer: no change.
- SEND state:
  - Each edge with tx_en=1 drives the next bit: parity, then d6 .. d0 (8 bits).
  - Then the first stop bit (tx<=1), going to STOP.
  - tx_en=0 edges hold all state.
- STOP state:
  - tx held 1.
  - Counts tx_en strobes; after STOP_BITS stop periods have elapsed, returns to IDLE.
  - Back-to-back frames: the tx_en edge that ends the last stop period may directly start the next frame (tx<=0) when the buffer is non-empty. There is no idle bit period between frames.
- Frame length is 9+STOP_BITS bit periods. A start bit begins on the tx_en edge after data is buffered, or later.
- busy=1 from the start-bit edge through the end of the last stop period. Set and cleared on the same edges as the state.
- Simultaneous push and pop in one cycle: both occur. Occupancy is unchanged; the popped entry is the older one.
- A push while full is impossible, because data_ready=0. data_valid while data_ready=0 is ignored: no overwrite, no error.
- tx_en asserted on consecutive cycles: each cycle is a bit period. No minimum strobe spacing applies.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined:
  - The buffer is a FIFO_DEPTH-entry circular FIFO: write/read pointers with wrap-around, plus an occupancy count 0..FIFO_DEPTH.
  - data_ready = (count != FIFO_DEPTH).
  - Frames are sent in arrival order.
- Undefined: the buffer is a single holding register and FIFO_DEPTH is ignored.

Test Plan:
- Reset, then data_in=7'h41, one valid cycle, tx_en every 4 cycles -> tx sequence per bit period is 0,0,1,0,0,0,0,0,1,1 (parity=0); busy=0 afterwards; tx=1.
- data_in=7'h07, PARITY_ODD=0 -> 0,1,0,0,0,0,1,1,1,1 with parity=1. Rerun with PARITY_ODD=1 -> parity bit 0.
- Push 7'h41 then 7'h07 back-to-back (FIFO build, STOP_BITS=2) -> two frames of 11 bit periods each, no idle period between them, in order.
- FIFO build, tx_en=0, push 4 words -> data_ready=0 after the 4th. A 5th valid word is dropped. Enable tx_en -> exactly 4 frames are sent.
- Non-FIFO build: push while a frame is in flight and the holding register is full -> data_ready=0; it returns to 1 on the edge that pops the register.
- Assert reset during bit d3 of a frame -> tx=1, busy=0, data_ready=1 on that edge; no further bits are sent.
- Loopback into the receiver -> received 7 bits equal the sent data, error=0.
